// File: rtl/conv_window_buffer.sv
// -----------------------------------------------------------------------------
// conv_window_buffer
//
// Line buffer and window generator that feeds the 5x5 convolution unit.
// A raster-order stream of signed Q4.11 pixels is collected into KSIZE
// circular row slots. Once KSIZE rows are held, every valid KSIZE x KSIZE
// window (stride 1, no padding) is handed to the conv unit through a
// start/finish handshake. The pixel stream is throttled while windows of
// the current row band are being issued.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pix_data     input pixel (signed Q4.11, passed through untouched)
//   pix_valid    pix_data valid
//   pix_ready    buffer accepts a pixel (transfer on pix_valid & pix_ready)
//   window_o     KSIZE*KSIZE pixels, element [r][c] at (r*KSIZE+c)*DW,
//                r=0 is the oldest (top) row, c=0 the leftmost column
//   conv_start   window_o valid, request to the conv unit
//   conv_finish  conv unit is done with the current window
//   frame_done   one-cycle pulse after the last window of a frame
//   win_count    (optional) windows issued since reset / frame start
//   stall_cycles (optional) ISSUE cycles without conv_finish, saturating
//
// Optional feature macro: CONV_WINDOW_BUFFER_STATS_EN adds win_count and
// stall_cycles. Without it neither the ports nor the counters exist.
// -----------------------------------------------------------------------------
module conv_window_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int KSIZE = 5,
  parameter int DW    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DW-1:0]             pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [KSIZE*KSIZE*DW-1:0] window_o,
  output logic                      conv_start,
  input  logic                      conv_finish,
  output logic                      frame_done
`ifdef CONV_WINDOW_BUFFER_STATS_EN
  ,
  output logic [15:0]               win_count,
  output logic [15:0]               stall_cycles
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int SW = $clog2(KSIZE);
  localparam int WW = KSIZE * KSIZE * DW;

  localparam logic [CW-1:0] LAST_COL     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_OUT_COL = CW'(IMG_W - KSIZE);
  localparam logic [RW-1:0] K_ROWS       = RW'(KSIZE);
  localparam logic [RW-1:0] H_ROWS       = RW'(IMG_H);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Slot index (base + off) mod KSIZE; off is always below KSIZE.
  function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] base,
                                             input int unsigned   off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(KSIZE)) begin
      s = s - 32'(KSIZE);
    end else begin
      s = s;
    end
    return SW'(s);
  endfunction

  // Column index base + off, clamped to the row so unused windows never
  // read beyond the stored line.
  function automatic logic [CW-1:0] col_sel(input logic [CW-1:0] base,
                                            input int unsigned   off);
    int unsigned s;
    s = 32'(base) + off;
    if (s > 32'(IMG_W - 1)) begin
      s = 32'(IMG_W - 1);
    end else begin
      s = s;
    end
    return CW'(s);
  endfunction

  state_e          state_q;
  logic [DW-1:0]   mem_q [KSIZE][IMG_W];
  logic [CW-1:0]   wcol_q;
  logic [CW-1:0]   out_col_q;
  logic [RW-1:0]   rows_in_q;
  logic [SW-1:0]   top_slot_q;
  logic [WW-1:0]   window_q;
  logic            conv_start_q;
  logic            frame_done_q;
`ifdef CONV_WINDOW_BUFFER_STATS_EN
  logic [15:0]     win_count_q;
  logic [15:0]     stall_cycles_q;
`endif

  logic            wr_en;
  logic            row_done;
  logic [SW-1:0]   top_d;
  logic [CW-1:0]   win_col_d;
  logic [WW-1:0]   win_d;

  // Next window contents. Entering ISSUE from LOAD uses column 0 and the
  // already-advanced top slot; the pixel being written on that same edge is
  // bypassed in so the window includes the final pixel of the row.
  always_comb begin
    wr_en     = (state_q == S_LOAD) && pix_valid;
    row_done  = wr_en && (wcol_q == LAST_COL);
    top_d     = row_done ? slot_add(top_slot_q, 1) : top_slot_q;
    win_col_d = (state_q == S_GAP) ? (out_col_q + CW'(1)) : '0;
    win_d     = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        win_d[(r*KSIZE+c)*DW +: DW] =
          (wr_en && (slot_add(top_d, r) == top_slot_q) &&
           (col_sel(win_col_d, c) == wcol_q))
            ? pix_data
            : mem_q[slot_add(top_d, r)][col_sel(win_col_d, c)];
      end
    end
  end

  // Window FSM: row storage, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      wcol_q       <= '0;
      out_col_q    <= '0;
      rows_in_q    <= '0;
      top_slot_q   <= '0;
      window_q     <= '0;
      conv_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      for (int s = 0; s < KSIZE; s++) begin
        for (int c = 0; c < IMG_W; c++) begin
          mem_q[s][c] <= '0;
        end
      end
`ifdef CONV_WINDOW_BUFFER_STATS_EN
      win_count_q    <= 16'd0;
      stall_cycles_q <= 16'd0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (wr_en) begin
        mem_q[top_slot_q][wcol_q] <= pix_data;
      end
      case (state_q)
        S_LOAD: begin
          if (wr_en) begin
            if (wcol_q == LAST_COL) begin
              wcol_q     <= '0;
              rows_in_q  <= rows_in_q + RW'(1);
              top_slot_q <= top_d;
              if ((rows_in_q + RW'(1)) >= K_ROWS) begin
                state_q      <= S_ISSUE;
                out_col_q    <= '0;
                window_q     <= win_d;
                conv_start_q <= 1'b1;
              end
            end else begin
              wcol_q <= wcol_q + CW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (conv_finish) begin
            state_q      <= S_GAP;
            conv_start_q <= 1'b0;
`ifdef CONV_WINDOW_BUFFER_STATS_EN
            win_count_q  <= win_count_q + 16'd1;
`endif
          end else begin
`ifdef CONV_WINDOW_BUFFER_STATS_EN
            if (stall_cycles_q != 16'hFFFF) begin
              stall_cycles_q <= stall_cycles_q + 16'd1;
            end
`endif
          end
        end
        S_GAP: begin
          if (out_col_q < LAST_OUT_COL) begin
            state_q      <= S_ISSUE;
            out_col_q    <= out_col_q + CW'(1);
            window_q     <= win_d;
            conv_start_q <= 1'b1;
          end else if (rows_in_q < H_ROWS) begin
            // Next row replaces the oldest slot, which top_slot points at.
            state_q <= S_LOAD;
          end else begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_LOAD;
          wcol_q     <= '0;
          out_col_q  <= '0;
          rows_in_q  <= '0;
          top_slot_q <= '0;
`ifdef CONV_WINDOW_BUFFER_STATS_EN
          win_count_q    <= 16'd0;
          stall_cycles_q <= 16'd0;
`endif
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  // Ready is a pure state decode so it is high in the very first cycle
  // after reset release; gating with rst_n keeps it low during reset.
  assign pix_ready  = (state_q == S_LOAD) && rst_n;
  assign window_o   = window_q;
  assign conv_start = conv_start_q;
  assign frame_done = frame_done_q;
`ifdef CONV_WINDOW_BUFFER_STATS_EN
  assign win_count    = win_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for conv_window_buffer (IMG_W=8, IMG_H=7, KSIZE=5).
// Expected windows are computed from the image definition: window k covers
// image rows k/4..k/4+4 and columns k%4..k%4+4. A small conv-unit responder
// raises conv_finish a programmable number of cycles into each request.
// -----------------------------------------------------------------------------
module tb_conv_window_buffer;

  localparam int W   = 8;
  localparam int H   = 7;
  localparam int K   = 5;
  localparam int DW  = 16;
  localparam int WW  = K * K * DW;
  localparam int NWC = W - K + 1;
  localparam int NWIN = NWC * (H - K + 1);
  localparam int NPIX = W * H;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [WW-1:0] window_o;
  logic          conv_start;
  logic          conv_finish;
  logic          frame_done;
`ifdef CONV_WINDOW_BUFFER_STATS_EN
  logic [15:0]   win_count;
  logic [15:0]   stall_cycles;
`endif

  conv_window_buffer #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .window_o    (window_o),
    .conv_start  (conv_start),
    .conv_finish (conv_finish),
    .frame_done  (frame_done)
`ifdef CONV_WINDOW_BUFFER_STATS_EN
    ,
    .win_count   (win_count),
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int delay    = 0;
  logic finish_idle = 1'b0;
  int frames_seen = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cap_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    $display("FAIL %s: got event want none", name);
  endtask

  // Image definition: kind 0 = constant 1.0 (2048), kind 1 = row*8+col.
  function automatic logic [DW-1:0] pix_val(input int kind, input int p);
    if (kind == 0) return 16'd2048;
    else return DW'(p);
  endfunction

  function automatic logic [WW-1:0] model_win(input int kind, input int k);
    logic [WW-1:0] w;
    int orow;
    int ocol;
    w = '0;
    orow = k / NWC;
    ocol = k % NWC;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = pix_val(kind, (orow + r) * W + ocol + c);
    return w;
  endfunction

  function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int r, input int c);
    return w[(r*K+c)*DW +: DW];
  endfunction

  // Conv unit responder: finish on the (delay+1)-th cycle of each request.
  initial begin
    int hi;
    hi = 0;
    conv_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (conv_start) begin
        conv_finish = (hi >= delay);
        hi++;
      end else begin
        conv_finish = finish_idle;
        hi = 0;
      end
    end
  end

  // Compare process: checks outputs against the model on every cycle.
  initial begin
    logic prev_cs, prev2_cs, prev_fd;
    int hi_len, win_in_frame;
    prev_cs = 0; prev2_cs = 0; prev_fd = 0; hi_len = 0; win_in_frame = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs = 0; prev2_cs = 0; prev_fd = 0; hi_len = 0; win_in_frame = 0;
      end else begin
        if (conv_start) begin
          if (!prev_cs) cap_q.push_back(window_o);
          if (exp_q.size() > 0) chk_w("window", window_o, exp_q[0]);
          else fail_msg("extra window");
          chk("pix_ready in issue", {31'd0, pix_ready}, 32'd0);
          hi_len++;
        end else if (prev_cs) begin
          chk("pix_ready in gap", {31'd0, pix_ready}, 32'd0);
          chk("issue length", hi_len, delay + 1);
          if (exp_q.size() > 0) exp_q.delete(0);
          hi_len = 0;
          win_in_frame++;
        end
        if (frame_done) begin
          chk("windows per frame", win_in_frame, NWIN);
          chk("done after gap", {30'd0, prev2_cs, prev_cs}, 32'd2);
`ifdef CONV_WINDOW_BUFFER_STATS_EN
          chk("win_count", {16'd0, win_count}, NWIN);
          chk("stall_cycles", {16'd0, stall_cycles}, NWIN * delay);
`endif
          win_in_frame = 0;
          frames_seen++;
        end
        if (prev_fd) chk("frame_done width", {31'd0, frame_done}, 32'd0);
        prev2_cs = prev_cs;
        prev_cs  = conv_start;
        prev_fd  = frame_done;
      end
    end
  end

  // Push npix pixels of the given image (wrapping per frame) into the DUT.
  task automatic stream(input int kind, input int npix, input bit bursty);
    int idx;
    int budget;
    bit tog;
    idx = 0; budget = 0; tog = 0;
    while (idx < npix && budget < 20000) begin
      @(negedge clk);
      budget++;
      tog = ~tog;
      pix_valid = bursty ? tog : 1'b1;
      pix_data  = pix_val(kind, idx % NPIX);
      if (pix_valid && pix_ready) idx++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    if (idx < npix) fail_msg("stream timeout");
  endtask

  task automatic run_frames(input int kind, input int nframes, input bit bursty,
                            input int dly, input logic idle);
    int target;
    int budget;
    delay = dly;
    finish_idle = idle;
    cap_q.delete();
    for (int f = 0; f < nframes; f++)
      for (int k = 0; k < NWIN; k++)
        exp_q.push_back(model_win(kind, k));
    target = frames_seen + nframes;
    stream(kind, nframes * NPIX, bursty);
    budget = 0;
    while (frames_seen < target && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (frames_seen < target) fail_msg("frame_done timeout");
    chk("windows left", exp_q.size(), 0);
    chk("windows captured", cap_q.size(), nframes * NWIN);
  endtask

  initial begin
    logic [WW-1:0] mw;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    repeat (2) @(negedge clk);
    chk("reset pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("reset conv_start", {31'd0, conv_start}, 32'd0);
    chk_w("reset window", window_o, '0);
    rst_n = 1'b1;
    #1;
    chk("ready after release", {31'd0, pix_ready}, 32'd1);

    // Pin the model with hand-computed ramp values.
    mw = model_win(1, 0);
    chk("model w0[4][4]", {16'd0, elem(mw, 4, 4)}, 32'd36);
    mw = model_win(1, 5);
    chk("model w5[0][0]", {16'd0, elem(mw, 0, 0)}, 32'd9);

    // Constant frame, conv_finish tied high.
    run_frames(0, 1, 1'b0, 0, 1'b1);
    if (cap_q.size() > 0) chk("const elem", {16'd0, elem(cap_q[0], 2, 3)}, 32'd2048);
    else fail_msg("const capture");

    // Reset in the middle of loading.
    finish_idle = 1'b0;
    stream(1, 12, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("midreset conv_start", {31'd0, conv_start}, 32'd0);
    chk("midreset frame_done", {31'd0, frame_done}, 32'd0);
    chk_w("midreset window", window_o, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset ready after", {31'd0, pix_ready}, 32'd1);

    // Ramp frame restarting from row 0, with literal spot checks.
    run_frames(1, 1, 1'b0, 0, 1'b0);
    if (cap_q.size() == NWIN) begin
      chk("ramp w0[0][0]", {16'd0, elem(cap_q[0], 0, 0)}, 32'd0);
      chk("ramp w0[4][4]", {16'd0, elem(cap_q[0], 4, 4)}, 32'd36);
      chk("ramp w5[0][0]", {16'd0, elem(cap_q[5], 0, 0)}, 32'd9);
      chk("ramp w5[4][4]", {16'd0, elem(cap_q[5], 4, 4)}, 32'd45);
      chk("ramp w11[4][4]", {16'd0, elem(cap_q[11], 4, 4)}, 32'd55);
    end else begin
      fail_msg("ramp capture count");
    end

    // Slow conv unit: finish 3 cycles after each request.
    run_frames(1, 1, 1'b0, 3, 1'b0);
    // Bursty input.
    run_frames(1, 1, 1'b1, 1, 1'b0);
    // Back-to-back frames.
    run_frames(1, 2, 1'b0, 0, 1'b0);
    if (cap_q.size() == 2 * NWIN)
      chk("frame2 w11[4][4]", {16'd0, elem(cap_q[23], 4, 4)}, 32'd55);
    else
      fail_msg("b2b capture count");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
